// File: rtl/md_pkg.sv
// Shared definitions for the iterative multiply/divide engine:
// operation encodings, FSM state encoding, datapath sizing.
package md_pkg;

   localparam int unsigned MD_WIDTH = 32;
   localparam int unsigned MD_ITER  = 32;
   localparam int unsigned MD_CNT_W = 5;

   localparam logic MD_OP_MUL = 1'b0;
   localparam logic MD_OP_DIV = 1'b1;

   typedef enum logic [1:0] {
      MD_IDLE = 2'd0,
      MD_CALC = 2'd1,
      MD_FIX  = 2'd2,
      MD_DONE = 2'd3
   } md_state_e;

endpackage : md_pkg

// File: rtl/muldiv_engine.sv
// Iterative 32-bit MULT/MULTU/DIV/DIVU engine for the EX stage.
// One shared datapath: radix-2 shift-add multiply / restoring divide on
// operand magnitudes (32 CALC cycles), then one FIX cycle for signs.
// Ports:
//   clk, rst        rising-edge clock, async active-low reset
//   src_a, src_b    multiplicand/dividend, multiplier/divisor
//   en, op, sign    request, 0=mul 1=div, 1=signed
//   pipe_stall      hold a finished result in DONE
//   flush           abort any operation
//   s, r            LO (product low / quotient), HI (product high / remainder)
//   res_ready       result valid on s/r
//   stall_all       combinational pipeline freeze while the op is in progress
module muldiv_engine
   import md_pkg::*;
#(
   parameter int unsigned WIDTH = MD_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [WIDTH-1:0] src_a,
   input  logic [WIDTH-1:0] src_b,
   input  logic             en,
   input  logic             op,
   input  logic             sign,
   input  logic             pipe_stall,
   input  logic             flush,
   output logic [WIDTH-1:0] s,
   output logic [WIDTH-1:0] r,
   output logic             res_ready,
   output logic             stall_all
);

   localparam int unsigned              PW       = 2 * WIDTH;
   localparam logic [MD_CNT_W-1:0]      CNT_LAST = MD_CNT_W'(MD_ITER - 1);

   // Conditional two's-complement negate (magnitude and sign fix-up)
   function automatic logic [WIDTH-1:0] f_cneg(input logic [WIDTH-1:0] v,
                                                input logic             neg);
      return neg ? -v : v;
   endfunction

   md_state_e               r_state, w_state_nxt;
   logic                    r_op;
   logic                    r_neg_q;     // negate product / quotient
   logic                    r_neg_r;     // negate remainder (dividend negative)
   logic [MD_CNT_W-1:0]     r_cnt;
   logic [WIDTH-1:0]        r_hi;        // product high / partial remainder
   logic [WIDTH-1:0]        r_lo;        // product low (multiplier) / quotient
   logic [WIDTH-1:0]        r_opb;       // |multiplicand| or |divisor|
   logic [WIDTH-1:0]        r_s, r_r;
   logic                    r_res_ready;
   logic                    w_start;
   logic                    w_stall_all;
   logic                    w_a_neg, w_b_neg;
   logic [WIDTH:0]          w_add;
   logic [WIDTH:0]          w_shrem;
   logic [WIDTH+1:0]        w_trial;
   logic                    w_ge;
   logic [PW-1:0]           w_prod, w_prod_neg;

   assign w_a_neg = sign & src_a[WIDTH-1];
   assign w_b_neg = sign & src_b[WIDTH-1];

   // Multiply step: add multiplicand when the current multiplier bit is set
   assign w_add = r_lo[0] ? ({1'b0, r_hi} + {1'b0, r_opb}) : {1'b0, r_hi};

   // Divide step: shift in next dividend bit, trial-subtract the divisor
   assign w_shrem = {r_hi, r_lo[WIDTH-1]};
   assign w_trial = {1'b0, w_shrem} - {2'b00, r_opb};
   assign w_ge    = ~w_trial[WIDTH+1];

   assign w_prod     = {r_hi, r_lo};
   assign w_prod_neg = -w_prod;

   // State register
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= MD_IDLE;
      else      r_state <= w_state_nxt;
   end

   // Next state and combinational stall
   always_comb begin
      w_state_nxt = r_state;
      w_start     = 1'b0;
      w_stall_all = 1'b0;
      case (r_state)
         MD_IDLE: w_stall_all = en & ~flush;
         MD_CALC: w_stall_all = 1'b1;
         MD_FIX:  w_stall_all = 1'b1;
         default: w_stall_all = 1'b0;
      endcase
      if (flush) begin
         w_state_nxt = MD_IDLE;
      end else begin
         case (r_state)
            MD_IDLE: if (en) begin
               w_start     = 1'b1;
               w_state_nxt = MD_CALC;
            end
            MD_CALC: if (r_cnt == CNT_LAST) w_state_nxt = MD_FIX;
            MD_FIX:  w_state_nxt = MD_DONE;
            MD_DONE: if (!pipe_stall) w_state_nxt = MD_IDLE;
            default: w_state_nxt = MD_IDLE;
         endcase
      end
   end

   // Datapath and result registers
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_op        <= MD_OP_MUL;
         r_neg_q     <= 1'b0;
         r_neg_r     <= 1'b0;
         r_cnt       <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_opb       <= '0;
         r_s         <= '0;
         r_r         <= '0;
         r_res_ready <= 1'b0;
      end else begin
         r_res_ready <= (w_state_nxt == MD_DONE);
         if (w_start) begin
            r_op    <= op;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_cnt   <= '0;
            r_hi    <= '0;
            if (op == MD_OP_MUL) begin
               r_lo  <= f_cneg(src_b, w_b_neg);
               r_opb <= f_cneg(src_a, w_a_neg);
            end else begin
               r_lo  <= f_cneg(src_a, w_a_neg);
               r_opb <= f_cneg(src_b, w_b_neg);
            end
         end else if (r_state == MD_CALC && !flush) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_op == MD_OP_MUL) begin
               r_hi <= w_add[WIDTH:1];
               r_lo <= {w_add[0], r_lo[WIDTH-1:1]};
            end else begin
               r_hi <= w_ge ? WIDTH'(w_trial) : WIDTH'(w_shrem);
               r_lo <= {r_lo[WIDTH-2:0], w_ge};
            end
         end else if (r_state == MD_FIX && !flush) begin
            if (r_op == MD_OP_MUL) begin
               {r_r, r_s} <= r_neg_q ? w_prod_neg : w_prod;
            end else begin
               r_s <= f_cneg(r_lo, r_neg_q);
               r_r <= f_cneg(r_hi, r_neg_r);
            end
         end
      end
   end

   assign s         = r_s;
   assign r         = r_r;
   assign res_ready = r_res_ready;
   assign stall_all = w_stall_all;

endmodule : muldiv_engine

// File: tb/tb_muldiv_engine.sv
// Scoreboard bench for muldiv_engine: driver pushes model results into a
// queue, a monitor pops and compares on each new res_ready.
module tb_muldiv_engine;

   typedef struct packed {
      logic [31:0] r;
      logic [31:0] s;
   } exp_t;

   logic        clk, rst;
   logic [31:0] src_a, src_b;
   logic        en, op, sign, pipe_stall, flush;
   logic [31:0] s, r;
   logic        res_ready, stall_all;

   exp_t exp_q[$];
   exp_t last_exp;
   int   n_checks = 0;
   int   n_pass   = 0;

   muldiv_engine #(.WIDTH(32)) dut (
      .clk(clk), .rst(rst), .src_a(src_a), .src_b(src_b), .en(en), .op(op),
      .sign(sign), .pipe_stall(pipe_stall), .flush(flush), .s(s), .r(r),
      .res_ready(res_ready), .stall_all(stall_all)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
   endtask

   // Reference: plain 64-bit arithmetic, truncating signed division
   function automatic exp_t model(input logic [31:0] a, input logic [31:0] b,
                                  input logic o, input logic sg);
      exp_t        e;
      logic [63:0] p;
      longint      sa, sb, q, rm;
      logic        aneg;
      sa = sg ? longint'($signed(a)) : longint'({32'd0, a});
      sb = sg ? longint'($signed(b)) : longint'({32'd0, b});
      aneg = sg && a[31];
      if (o == 1'b0) begin
         p   = 64'(sa * sb);
         e.r = p[63:32];
         e.s = p[31:0];
      end else if (b == 32'd0) begin
         // magnitude quotient all ones, remainder |a|, then sign fix-up
         e.s = 32'hFFFF_FFFF;
         e.r = aneg ? 32'(-a) : a;
         if (aneg) begin
            e.s = 32'(-e.s);
            e.r = 32'(-e.r);
         end
      end else begin
         q   = sa / sb;
         rm  = sa % sb;
         e.s = 32'(q);
         e.r = 32'(rm);
      end
      return e;
   endfunction

   function automatic logic [31:0] rand_operand();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h8000_0000;
         2: return 32'hFFFF_FFFF;
         3: return 32'($urandom_range(0, 300));
         4: return 32'(-$urandom_range(1, 300));
         default: return 32'($urandom);
      endcase
   endfunction

   // Full operation with latency/stall checks; nstall cycles of pipe_stall in DONE
   task automatic run_op(input logic [31:0] a, input logic [31:0] b,
                         input logic o, input logic sg, input int nstall);
      exp_t e;
      logic ok;
      @(negedge clk);
      src_a = a; src_b = b; op = o; sign = sg; en = 1'b1;
      e = model(a, b, o, sg);
      exp_q.push_back(e);
      last_exp = e;
      #1;
      check("start_stall", stall_all, 1);
      check("start_ready", res_ready, 0);
      ok = 1'b1;
      for (int c = 1; c <= 33; c++) begin
         @(negedge clk);
         if (!(stall_all === 1'b1 && res_ready === 1'b0)) ok = 1'b0;
         src_a = $urandom; src_b = $urandom;
         op = 1'($urandom); sign = 1'($urandom);
      end
      check("busy_window", ok, 1);
      @(negedge clk);
      check("done_stall", stall_all, 0);
      check("done_ready", res_ready, 1);
      en = 1'b0;
      pipe_stall = (nstall > 0);
      for (int k = 1; k <= nstall; k++) begin
         @(negedge clk);
         check("stall_hold_ready", res_ready, 1);
         if (k == nstall) pipe_stall = 1'b0;
      end
   endtask

   // Monitor: pop on each rising res_ready, check hold while it stays high
   initial begin
      logic prev_rdy;
      exp_t e, hold;
      prev_rdy = 1'b0;
      hold     = '0;
      forever begin
         @(negedge clk);
         if (rst !== 1'b1) begin
            prev_rdy = 1'b0;
         end else begin
            if (res_ready === 1'b1 && !prev_rdy) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_result", res_ready, 0);
               end else begin
                  e = exp_q.pop_front();
                  check("result_s", s, e.s);
                  check("result_r", r, e.r);
                  hold = e;
               end
            end else if (res_ready === 1'b1) begin
               check("hold_s", s, hold.s);
               check("hold_r", r, hold.r);
            end
            prev_rdy = (res_ready === 1'b1);
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int ready_seen;
      rst = 1'b0; en = 1'b0; op = 1'b0; sign = 1'b0;
      pipe_stall = 1'b0; flush = 1'b0; src_a = '0; src_b = '0;
      last_exp = '0;
      repeat (2) @(negedge clk);
      check("rst_s", s, 0);
      check("rst_r", r, 0);
      check("rst_ready", res_ready, 0);
      check("rst_stall", stall_all, 0);
      rst = 1'b1;

      // Directed cases
      run_op(32'hFFFF_FFFD, 32'd5,         1'b0, 1'b1, 0);
      run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0, 0);
      run_op(32'd100,       32'd7,         1'b1, 1'b0, 0);
      run_op(32'hFFFF_FFF9, 32'd2,         1'b1, 1'b1, 0);
      run_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 1'b1, 0);
      run_op(32'd5,         32'd0,         1'b1, 1'b0, 3);
      run_op(32'hFFFF_FFFB, 32'd0,         1'b1, 1'b1, 0);

      // Flush at cycle 10 of a divide
      @(negedge clk);
      src_a = $urandom; src_b = 32'd3; op = 1'b1; sign = 1'b1; en = 1'b1;
      repeat (10) @(negedge clk);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; en = 1'b0;
      #1;
      check("flush_idle_stall", stall_all, 0);
      ready_seen = 0;
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         if (res_ready === 1'b1) ready_seen++;
      end
      check("flush_no_ready", ready_seen, 0);
      check("flush_keep_s", s, last_exp.s);
      check("flush_keep_r", r, last_exp.r);

      // flush and en together in IDLE: nothing starts
      @(negedge clk);
      en = 1'b1; flush = 1'b1; src_a = $urandom; src_b = $urandom;
      #1;
      check("flush_en_stall", stall_all, 0);
      @(negedge clk);
      en = 1'b0; flush = 1'b0;
      #1;
      check("flush_en_nostart", stall_all, 0);

      // Asynchronous reset mid-operation
      @(negedge clk);
      src_a = 32'd1234; src_b = 32'd77; op = 1'b0; sign = 1'b0; en = 1'b1;
      repeat (20) @(negedge clk);
      en = 1'b0; rst = 1'b0;
      #1;
      check("midrst_s", s, 0);
      check("midrst_r", r, 0);
      check("midrst_ready", res_ready, 0);
      check("midrst_stall", stall_all, 0);
      @(negedge clk);
      rst = 1'b1;
      last_exp = '0;

      // Randomized back-to-back traffic
      for (int i = 0; i < 30; i++) begin
         run_op(rand_operand(), rand_operand(), 1'($urandom), 1'($urandom),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end

      repeat (5) @(negedge clk);
      check("queue_empty", exp_q.size(), 0);
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule : tb_muldiv_engine

// File: doc/muldiv_engine.md
# muldiv_engine

Iterative 32-bit multiply/divide responder for the EX stage; the ALU drives the request side (`en`, sign, operands) and this block serves MULT/MULTU/DIV/DIVU over 34 cycles. It exposes the `res_ready`/`stall_all` handshake the ALU already consumes. One shared datapath does radix-2 shift-add multiply and restoring divide on operand magnitudes, with a sign fix-up at the end. HI/LO results go back through the ALU to the HI/LO write path.

## Interface
- `WIDTH`, 32, operand/result width; only 32 is supported.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset (named `rst` per codebase; low = reset).
- `src_a`  in  32  multiplicand / dividend.
- `src_b`  in  32  multiplier / divisor.
- `en`  in  1  request; held high by the ALU while the instruction sits in EX.
- `op`  in  1  0 = multiply, 1 = divide.
- `sign`  in  1  1 = signed (MULT/DIV), 0 = unsigned.
- `pipe_stall`  in  1  stall from elsewhere in the pipeline; keeps a finished result presented.
- `flush`  in  1  exception/flush; aborts any operation.
- `s`  out  32  LO: product[31:0] or quotient.
- `r`  out  32  HI: product[63:32] or remainder.
- `res_ready`  out  1  result valid on `s`/`r`.
- `stall_all`  out  1  freeze the pipeline; the operation is still in progress.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE, `en=1`, `flush=0`:
  - latch `op` and `sign`;
  - latch |src_a| and |src_b| (two's-complement negate only if `sign` is set and bit 31 is set);
  - latch the result-sign flags;
  - clear the 5-bit counter; go to CALC.
- CALC (exactly 32 cycles, counter 0..31):
  - multiply: 64-bit accumulator {hi,lo}, conditional add of the multiplicand, shift right one bit per cycle;
  - divide: restoring; shift {rem,quo} left, trial-subtract the 33-bit divisor, set the quotient bit when the result is non-negative.
  - Counter 31 → FIX.
- FIX (1 cycle) applies signs:
  - multiply: negate the 64-bit product if the operand signs differ;
  - divide: negate the quotient if the operand signs differ; negate the remainder if the dividend was negative.
  - Then register `s`/`r` and go to DONE.
- DONE: `res_ready=1`.
  - `pipe_stall=1` → stay in DONE.
  - Otherwise → IDLE, ready to accept the next `en` in the following cycle (back-to-back ops cost one idle cycle).
- `stall_all` = (IDLE & `en` & ~`flush`) | CALC | FIX. It is combinational and never high in DONE.
- `flush=1` in any state → IDLE next edge. No `res_ready` is produced for the aborted op. `s`/`r` keep their previous values.
- Divide by zero: no trap; same latency. Raw magnitude result is quotient 0xFFFFFFFF and remainder |src_a|; the normal sign fix-up is then applied.
- 0x80000000 / 0xFFFFFFFF signed → s=0x80000000, r=0 (natural wrap, no exception).
- Operand changes after the start cycle are ignored.

## Timing
- Reset values: state IDLE; `s`=0, `r`=0; `res_ready`=0; `stall_all`=0 (with `en`=0). Internal accumulator and counter are 0.
- Latency: `en` is first seen in IDLE at cycle 0 → CALC in cycles 1–32 → FIX in cycle 33 → `res_ready` in cycle 34.
- `stall_all` is high for cycles 0–33 and low in cycle 34.
- `s`/`r` are registered: valid from cycle 34 and held until the next FIX.
- Reset asserted mid-operation: immediate return to the reset values; no partial result.
- `flush` and `en` high together in IDLE: flush wins; nothing starts and `stall_all`=0.

## Structure
- Shared package `md_pkg`:
  - op encodings `MD_OP_MUL`=1'b0, `MD_OP_DIV`=1'b1;
  - state encoding (2 bits: IDLE=0, CALC=1, FIX=2, DONE=3);
  - `MD_ITER`=32.
- Single module; no sub-module. Magnitude/negate is a local function.
- Replaces the separate divider/multiplier instances behind the ALU's existing handshake.

## Test plan
- MULT −3 × 5 (0xFFFFFFFD, 5) → cycle 34: r=0xFFFFFFFF, s=0xFFFFFFF1, `res_ready`=1; `stall_all` high for cycles 0–33.
- MULTU 0xFFFFFFFF × 0xFFFFFFFF → r=0xFFFFFFFE, s=0x00000001.
- DIVU 100 / 7 → s=14, r=2. DIV −7 / 2 → s=0xFFFFFFFD, r=0xFFFFFFFF. DIV 0x80000000 / −1 → s=0x80000000, r=0.
- DIVU 5 / 0 → s=0xFFFFFFFF, r=5 at cycle 34, no hang.
- `flush` at cycle 10 of a DIV → IDLE at cycle 11, no `res_ready`, `s`/`r` keep their old values. Back-to-back: a second `en` right after DONE starts in the next IDLE cycle.
- `pipe_stall` held for 3 cycles in DONE → `res_ready` stays high 4 cycles with no restart. `rst` low at cycle 20 → all outputs return to 0 asynchronously.
